// File: rtl/fram_spi_master_ctrl.sv
// SPI master sequencer for an 18-bit-address FRAM-compatible SPI slave.
// Turns single READ / WRITE / RDSR / RDID requests into complete mode-0 SPI
// frames; every WRITE is preceded by its own WREN frame and a CS-high gap.
module fram_spi_master_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [17:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_sck,
  output logic        spi_cs,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RDSR  = 2'b10;
  localparam logic [1:0] OP_RDID  = 2'b11;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RELOAD = 8'(CS_GAP - 1);

  typedef enum logic [3:0] {
    IDLE, WREN_SETUP, WREN_SHIFT, WREN_HOLD, GAP, SETUP, SHIFT, HOLD, DONE
  } state_t;

  // Frame image, left-aligned in 40 bits; read bits are 0 so MOSI stays low.
  function automatic logic [39:0] frame_bits(input logic [1:0] op,
                                             input logic [17:0] addr,
                                             input logic [7:0] wdata);
    logic [23:0] a;
    a = {6'b0, addr};
    case (op)
      OP_READ:  frame_bits = {8'h03, a, 8'h00};
      OP_WRITE: frame_bits = {8'h02, a, wdata};
      OP_RDSR:  frame_bits = {8'h05, 32'h0000_0000};
      OP_RDID:  frame_bits = {8'h9F, 32'h0000_0000};
      default:  frame_bits = 40'h0;
    endcase
  endfunction

  function automatic logic [5:0] frame_len(input logic [1:0] op);
    frame_len = (op == OP_RDSR) ? 6'd16 : 6'd40;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hi_q, hi_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [5:0]  len_q, len_d;
  logic [39:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [1:0]  op_q, op_d;
  logic [17:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        sck_q, sck_d;
  logic        cs_q, cs_d;
  logic        mosi_q, mosi_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [39:0] req_frame_s;
  logic [39:0] main_frame_s;
  logic [31:0] result_s;

  assign req_frame_s  = frame_bits(req_op, req_addr, req_wdata);
  assign main_frame_s = frame_bits(op_q, addr_q, wdata_q);

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign spi_sck   = sck_q;
  assign spi_cs    = cs_q;
  assign spi_mosi  = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  // Response word formatting from the read shift register.
  always_comb begin
    case (op_q)
      OP_READ:  result_s = {24'h00_0000, rx_q[7:0]};
      OP_RDSR:  result_s = {24'h00_0000, rx_q[7:0]};
      OP_RDID:  result_s = rx_q;
      default:  result_s = 32'h0000_0000;
    endcase
  end

  // Next-state and pin sequencing; the divider counter reloads at every SCK edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    bit_cnt_d   = bit_cnt_q;
    len_d       = len_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sck_d       = sck_q;
    cs_d        = cs_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          cs_d      = 1'b0;
          sck_d     = 1'b0;
          cnt_d     = DIV_RELOAD;
          hi_d      = 1'b0;
          bit_cnt_d = 6'd0;
          rx_d      = 32'h0000_0000;
          if (req_op == OP_WRITE) begin
            tx_d    = {8'h06, 32'h0000_0000};
            len_d   = 6'd8;
            mosi_d  = 1'b0;
            state_d = WREN_SETUP;
          end else begin
            tx_d    = req_frame_s;
            len_d   = frame_len(req_op);
            mosi_d  = req_frame_s[39];
            state_d = SETUP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WREN_SETUP, SETUP: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = DIV_RELOAD;
          state_d = (state_q == WREN_SETUP) ? WREN_SHIFT : SHIFT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WREN_SHIFT, SHIFT: begin
        if (cnt_q == 8'd0) begin
          cnt_d = DIV_RELOAD;
          if (!hi_q) begin
            // Rising SCK: the slave's bit has been stable for a full low phase.
            sck_d = 1'b1;
            hi_d  = 1'b1;
            rx_d  = {rx_q[30:0], spi_miso};
          end else begin
            sck_d     = 1'b0;
            hi_d      = 1'b0;
            bit_cnt_d = bit_cnt_q + 6'd1;
            tx_d      = {tx_q[38:0], 1'b0};
            if ((bit_cnt_q + 6'd1) == len_q) begin
              mosi_d  = 1'b0;
              state_d = (state_q == WREN_SHIFT) ? WREN_HOLD : HOLD;
            end else begin
              mosi_d = tx_q[38];
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WREN_HOLD, HOLD: begin
        if (cnt_q == 8'd0) begin
          cs_d = 1'b1;
          if (state_q == WREN_HOLD) begin
            cnt_d   = GAP_RELOAD;
            state_d = GAP;
          end else begin
            cnt_d   = 8'd1;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          cs_d      = 1'b0;
          cnt_d     = DIV_RELOAD;
          hi_d      = 1'b0;
          bit_cnt_d = 6'd0;
          tx_d      = main_frame_s;
          len_d     = frame_len(op_q);
          mosi_d    = main_frame_s[39];
          state_d   = SETUP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        // First DONE cycle launches the response pulse, second returns to IDLE.
        if (cnt_q != 8'd0) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = result_s;
          cnt_d       = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset parks the bus deselected with SCK low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      hi_q        <= 1'b0;
      bit_cnt_q   <= 6'd0;
      len_q       <= 6'd0;
      tx_q        <= 40'h0;
      rx_q        <= 32'h0000_0000;
      op_q        <= 2'b00;
      addr_q      <= 18'h0_0000;
      wdata_q     <= 8'h00;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      bit_cnt_q   <= bit_cnt_d;
      len_q       <= len_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sck_q       <= sck_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_fram_spi_master_ctrl.sv
// Bench for fram_spi_master_ctrl: two instances (CLK_DIV=2 and CLK_DIV=1)
// share one behavioural FRAM slave + byte memory through a select mux.
module tb_fram_spi_master_ctrl;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RDSR  = 2'b10;
  localparam logic [1:0] OP_RDID  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [17:0] req_addr = 18'h0;
  logic [7:0]  req_wdata = 8'h00;
  logic        sel = 1'b0;
  logic        miso = 1'b0;

  logic        rdy0, rv0, busy0, sck0, cs0, mosi0;
  logic        rdy1, rv1, busy1, sck1, cs1, mosi1;
  logic [31:0] rd0, rd1;

  logic        rdy_m, rv_m, busy_m, sck_m, cs_m, mosi_m;
  logic [31:0] rd_m;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fram_spi_master_ctrl #(.CLK_DIV(2), .CS_GAP(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rdy0),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_rdata(rd0), .busy(busy0),
    .spi_sck(sck0), .spi_cs(cs0), .spi_mosi(mosi0), .spi_miso(miso)
  );

  fram_spi_master_ctrl #(.CLK_DIV(1), .CS_GAP(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rdy1),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .busy(busy1),
    .spi_sck(sck1), .spi_cs(cs1), .spi_mosi(mosi1), .spi_miso(miso)
  );

  assign rdy_m  = sel ? rdy1  : rdy0;
  assign rv_m   = sel ? rv1   : rv0;
  assign rd_m   = sel ? rd1   : rd0;
  assign busy_m = sel ? busy1 : busy0;
  assign sck_m  = sel ? sck1  : sck0;
  assign cs_m   = sel ? cs1   : cs0;
  assign mosi_m = sel ? mosi1 : mosi0;

  // ---------------- behavioural FRAM slave ----------------
  logic [7:0]  mem [int];
  int          f_len[$];
  logic [63:0] f_dat[$];
  int          f_gap[$];
  logic [31:0] exp_q[$];
  int          s_bits = 0;
  logic [63:0] s_in = 64'h0;
  logic [7:0]  s_cmd = 8'h00;
  logic [31:0] s_out = 32'h0;
  logic        wel = 1'b0;
  logic        sck_p = 1'b0;
  logic        cs_p = 1'b1;
  int          gap_cnt = 0;
  int          sck_cs_err = 0;
  int          rsp_pulses = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!cs_m && cs_p) begin
        f_gap.push_back(gap_cnt);
        s_bits = 0;
        s_in   = 64'h0;
        s_out  = 32'h0;
      end
      if (cs_m && !cs_p) begin
        f_len.push_back(s_bits);
        f_dat.push_back(s_in);
      end
      if (cs_m) gap_cnt++;
      else gap_cnt = 0;
      if (cs_m && sck_m) sck_cs_err++;
      if (!cs_m && sck_m && !sck_p) begin
        s_in = {s_in[62:0], mosi_m};
        s_bits++;
        if (s_bits == 8) begin
          s_cmd = s_in[7:0];
          if (s_cmd == 8'h06) wel = 1'b1;
          else if (s_cmd == 8'h9F) s_out = 32'h047F4803;
          else if (s_cmd == 8'h05) s_out = {6'b0, wel, 1'b0, 24'h0};
        end
        if (s_bits == 32 && s_cmd == 8'h03)
          s_out = {(mem.exists(int'(s_in[17:0])) ? mem[int'(s_in[17:0])] : 8'hFF), 24'h0};
        if (s_bits == 40 && s_cmd == 8'h02 && wel)
          mem[int'(s_in[25:8])] = s_in[7:0];
      end
      if (!cs_m && !sck_m && sck_p) begin
        miso  = s_out[31];
        s_out = {s_out[30:0], 1'b0};
      end
      sck_p = sck_m;
      cs_p  = cs_m;
      if (rv_m) rsp_pulses++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] op, input logic [17:0] addr, input logic [7:0] wd,
                      output int acc_edge, output bit to);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    to = 1'b1; acc_edge = 0;
    for (int n = 0; n < 2000; n++) begin
      if (rdy_m) begin acc_edge = cyc + 1; to = 1'b0; break; end
      @(negedge clk);
    end
    if (!to) @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] d, output int rv_cyc, output bit to);
    to = 1'b1; d = 32'h0; rv_cyc = 0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (rv_m) begin d = rd_m; rv_cyc = cyc; to = 1'b0; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cs_m, sck_m, mosi_m, rv_m, rdy_m, busy_m} !== 6'b100010)
      $display("FAIL reset_pins: got %b want 100010", {cs_m, sck_m, mosi_m, rv_m, rdy_m, busy_m});
    else n_pass++;
    n_checks++;
    if (rd_m !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", rd_m);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int acc, rvc, p0; bit to; logic [31:0] d, e; logic [63:0] t;
    sel = 1'b0;
    f_len.delete(); f_dat.delete(); f_gap.delete();
    p0 = rsp_pulses;
    exp_q.push_back(32'h0);
    send(OP_WRITE, 18'h2A5A5, 8'hC3, acc, to);
    if (!to) wait_rsp(d, rvc, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL write_timeout: got %0d want 0", to); else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) $display("FAIL write_rdata: got %h want %h", d, e); else n_pass++;
    repeat (6) @(negedge clk);
    n_checks++;
    if (rsp_pulses - p0 !== 1) $display("FAIL write_rsp_count: got %0d want 1", rsp_pulses - p0);
    else n_pass++;
    n_checks++;
    if (f_len.size() !== 2) $display("FAIL write_frames: got %0d want 2", f_len.size());
    else begin
      n_pass++;
      t = f_dat[0];
      n_checks++;
      if (f_len[0] !== 8 || t[7:0] !== 8'h06)
        $display("FAIL wren_frame: got %0d bits %h want 8 bits 06", f_len[0], t[7:0]);
      else n_pass++;
      t = f_dat[1];
      n_checks++;
      if (f_len[1] !== 40 || t[39:0] !== 40'h0202A5A5C3)
        $display("FAIL write_frame: got %0d bits %h want 40 bits 0202a5a5c3", f_len[1], t[39:0]);
      else n_pass++;
      n_checks++;
      if (f_gap[1] < 4) $display("FAIL cs_gap: got %0d want >=4", f_gap[1]); else n_pass++;
    end
  endtask

  task automatic test_read();
    int acc, rvc, cs_edge; bit to; logic [31:0] d, e;
    sel = 1'b0;
    exp_q.push_back(32'h000000C3);
    send(OP_READ, 18'h2A5A5, 8'h00, acc, to);
    cs_edge = 0;
    if (!to) begin
      to = 1'b1;
      for (int n = 0; n < 1000; n++) begin
        @(negedge clk);
        if (cs_m) begin cs_edge = cyc; to = 1'b0; break; end
      end
    end
    if (!to) wait_rsp(d, rvc, to);
    n_checks++;
    if (to !== 1'b0) $display("FAIL read_timeout: got %0d want 0", to); else n_pass++;
    n_checks++;
    if (cs_edge - acc !== 164) $display("FAIL read_frame_time: got %0d want 164", cs_edge - acc);
    else n_pass++;
    n_checks++;
    if (rvc - cs_edge !== 1) $display("FAIL read_rsp_latency: got %0d want 1", rvc - cs_edge);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) $display("FAIL read_rdata: got %h want %h", d, e); else n_pass++;
  endtask

  task automatic test_rdid_rdsr();
    int acc, rvc; bit to; logic [31:0] d, e;
    sel = 1'b0;
    exp_q.push_back(32'h047F4803);
    send(OP_RDID, 18'h0, 8'h00, acc, to);
    if (!to) wait_rsp(d, rvc, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to !== 1'b0 || d !== e) $display("FAIL rdid: got %h want %h", d, e); else n_pass++;
    exp_q.push_back(32'h00000002);
    send(OP_RDSR, 18'h0, 8'h00, acc, to);
    if (!to) wait_rsp(d, rvc, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to !== 1'b0 || d !== e) $display("FAIL rdsr: got %h want %h", d, e); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int acc, rvc, p0; bit to; logic [31:0] d, e;
    sel = 1'b0;
    send(OP_READ, 18'h2A5A5, 8'h00, acc, to);
    to = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if (s_bits >= 20) begin to = 1'b0; break; end
      @(negedge clk);
    end
    p0 = rsp_pulses;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (to !== 1'b0 || cs_m !== 1'b1 || sck_m !== 1'b0)
      $display("FAIL midframe_reset_pins: got cs=%b sck=%b want cs=1 sck=0", cs_m, sck_m);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    n_checks++;
    if (rsp_pulses !== p0) $display("FAIL midframe_no_rsp: got %0d want %0d", rsp_pulses, p0);
    else n_pass++;
    exp_q.push_back(32'h000000C3);
    send(OP_READ, 18'h2A5A5, 8'h00, acc, to);
    if (!to) wait_rsp(d, rvc, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to !== 1'b0 || d !== e) $display("FAIL read_after_reset: got %h want %h", d, e); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc, rvc, rv_first, acc2; bit to; logic [31:0] d, e;
    sel = 1'b1;
    exp_q.push_back(32'h0);
    send(OP_WRITE, 18'h00000, 8'h5A, acc, to);
    if (!to) wait_rsp(d, rvc, to);
    e = exp_q.pop_front();
    exp_q.push_back(32'h0);
    send(OP_WRITE, 18'h3FFFF, 8'hA6, acc, to);
    if (!to) wait_rsp(d, rvc, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to !== 1'b0 || d !== e) $display("FAIL div1_write: got %h want %h", d, e); else n_pass++;
    exp_q.push_back(32'h0000005A);
    exp_q.push_back(32'h000000A6);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_READ; req_addr = 18'h00000;
    to = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (rdy_m) begin to = 1'b0; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_addr = 18'h3FFFF;
    if (!to) wait_rsp(d, rv_first, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to !== 1'b0 || d !== e) $display("FAIL b2b_first: got %h want %h", d, e); else n_pass++;
    acc2 = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rdy_m) begin acc2 = cyc; break; end
    end
    // req_ready is high in the cycle right after the rsp_valid cycle.
    n_checks++;
    if (acc2 - rv_first !== 1) $display("FAIL b2b_accept_gap: got %0d want 1", acc2 - rv_first);
    else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(d, rvc, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to !== 1'b0 || d !== e) $display("FAIL b2b_second: got %h want %h", d, e); else n_pass++;
    sel = 1'b0;
  endtask

  task automatic test_latch();
    int acc, rvc; bit to; logic [31:0] d, e; logic [63:0] t;
    sel = 1'b0;
    f_len.delete(); f_dat.delete(); f_gap.delete();
    exp_q.push_back(32'h0);
    send(OP_WRITE, 18'h15A3C, 8'h7E, acc, to);
    req_addr = 18'h3FFFF; req_wdata = 8'h00;
    repeat (30) @(negedge clk);
    req_addr = 18'h01234; req_wdata = 8'hFF;
    if (!to) wait_rsp(d, rvc, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to !== 1'b0 || d !== e) $display("FAIL latch_rsp: got %h want %h", d, e); else n_pass++;
    t = (f_dat.size() > 1) ? f_dat[1] : 64'h0;
    n_checks++;
    if (t[39:0] !== 40'h02015A3C7E) $display("FAIL latch_frame: got %h want 02015a3c7e", t[39:0]);
    else n_pass++;
    exp_q.push_back(32'h0000007E);
    send(OP_READ, 18'h15A3C, 8'h00, acc, to);
    if (!to) wait_rsp(d, rvc, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to !== 1'b0 || d !== e) $display("FAIL latch_readback: got %h want %h", d, e); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rdid_rdsr();
    test_reset_midframe();
    test_back_to_back();
    test_latch();
    n_checks++;
    if (sck_cs_err !== 0) $display("FAIL sck_while_cs_high: got %0d want 0", sck_cs_err);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
